// File: rtl/i2c_master_byte.sv
// Byte-level single-master I2C initiator for the clock-generator bus.
// It accepts one command at a time on a valid/ready port. A command runs an
// optional START, an optional 9-bit byte phase and an optional STOP.
// The pads are open-drain: an oe output of 1 pulls the line low.
module i2c_master_byte #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_start_i,
    input  logic       cmd_byte_i,
    input  logic       cmd_read_i,
    input  logic       cmd_ack_i,
    input  logic       cmd_stop_i,
    input  logic [7:0] tx_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_nack_o,
    output logic       busy_o,
    input  logic       scl_i,
    output logic       scl_oe_o,
    input  logic       sda_i,
    output logic       sda_oe_o
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_START, S_BIT, S_STOP} state_t;

    // Command latched on acceptance. START is decided at accept time and is not kept.
    typedef struct packed {
        logic       xfer;
        logic       read;
        logic       ack;
        logic       stop;
        logic [7:0] data;
    } cmd_t;

    state_t        state;
    cmd_t          cmd;
    cmd_t          cmd_in;
    logic [CW-1:0] cnt;
    logic [1:0]    qtr;
    logic [3:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          ninth;
    logic [1:0]    scl_s;
    logic [1:0]    sda_s;
    logic          scl_sync;
    logic          sda_sync;
    logic          rel_qtr;
    logic          qtr_end;

    assign cmd_in   = {cmd_byte_i, cmd_read_i, cmd_ack_i, cmd_stop_i, tx_data_i};
    assign scl_sync = scl_s[1];
    assign sda_sync = sda_s[1];

    // This is the quarter in which SCL is released and a slave may stretch the clock.
    assign rel_qtr = (state == S_START && qtr == 2'd1) ||
                     (state == S_BIT   && qtr == 2'd2) ||
                     (state == S_STOP  && qtr == 2'd1);

    // The released quarter waits on its last count until the synchronized SCL reads
    // high. This absorbs the synchronizer delay, so a quarter with no stretching
    // keeps its nominal length.
    assign qtr_end = (cnt == CNT_LAST) && !(rel_qtr && !scl_sync);

    // SDA level for a given bit: write data, then the master ACK on a read.
    // The slave owns SDA for read data and for the write ACK.
    function automatic logic sda_drive(input cmd_t c, input logic [3:0] idx);
        logic [2:0] k;
        k = 3'd7 - idx[2:0];
        if (idx == 4'd8) return c.read & c.ack;
        return ~c.read & ~c.data[k];
    endfunction

    // Two-flop synchronizers on the pad inputs. They reset to the idle-high bus level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
        end else begin
            scl_s <= {scl_s[0], scl_i};
            sda_s <= {sda_s[0], sda_i};
        end
    end

    // Command sequencer and quarter-tick bus engine with registered pad outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cmd         <= '0;
            cnt         <= '0;
            qtr         <= '0;
            bit_idx     <= '0;
            rx_shift    <= '0;
            ninth       <= 1'b0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rx_data_o   <= '0;
            rx_nack_o   <= 1'b0;
            busy_o      <= 1'b0;
            scl_oe_o    <= 1'b0;
            sda_oe_o    <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE, S_HOLD: begin
                    cnt     <= '0;
                    qtr     <= '0;
                    bit_idx <= '0;
                    if (cmd_valid_i) begin
                        cmd <= cmd_in;
                        if (cmd_start_i || (state == S_IDLE && cmd_byte_i)) begin
                            state       <= S_START;
                            cmd_ready_o <= 1'b0;
                            sda_oe_o    <= 1'b0;
                        end else if (cmd_byte_i) begin
                            state       <= S_BIT;
                            cmd_ready_o <= 1'b0;
                            scl_oe_o    <= 1'b1;
                            sda_oe_o    <= sda_drive(cmd_in, 4'd0);
                        end else if (cmd_stop_i && state == S_HOLD) begin
                            state       <= S_STOP;
                            cmd_ready_o <= 1'b0;
                            scl_oe_o    <= 1'b1;
                            sda_oe_o    <= 1'b1;
                        end
                        // In IDLE, a STOP or an empty command has no effect on the free bus.
                    end
                end
                default: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (qtr_end) begin
                        cnt <= '0;
                        qtr <= qtr + 2'd1;
                        case (state)
                            S_START: begin
                                case (qtr)
                                    2'd0: scl_oe_o <= 1'b0;
                                    2'd1: sda_oe_o <= 1'b1;
                                    2'd3: begin
                                        scl_oe_o <= 1'b1;
                                        busy_o   <= 1'b1;
                                        if (cmd.xfer) begin
                                            state    <= S_BIT;
                                            bit_idx  <= '0;
                                            sda_oe_o <= sda_drive(cmd, 4'd0);
                                        end else if (cmd.stop) begin
                                            state    <= S_STOP;
                                        end else begin
                                            state       <= S_HOLD;
                                            cmd_ready_o <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            S_BIT: begin
                                case (qtr)
                                    2'd1: scl_oe_o <= 1'b0;
                                    2'd2: begin
                                        if (bit_idx == 4'd8) ninth <= sda_sync;
                                        else                 rx_shift <= {rx_shift[6:0], sda_sync};
                                    end
                                    2'd3: begin
                                        scl_oe_o <= 1'b1;
                                        if (bit_idx != 4'd8) begin
                                            bit_idx  <= bit_idx + 4'd1;
                                            sda_oe_o <= sda_drive(cmd, bit_idx + 4'd1);
                                        end else if (cmd.stop) begin
                                            state    <= S_STOP;
                                            sda_oe_o <= 1'b1;
                                        end else begin
                                            state       <= S_HOLD;
                                            cmd_ready_o <= 1'b1;
                                            rsp_valid_o <= 1'b1;
                                            rx_data_o   <= rx_shift;
                                            rx_nack_o   <= ninth;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            S_STOP: begin
                                case (qtr)
                                    2'd0: scl_oe_o <= 1'b0;
                                    2'd1: sda_oe_o <= 1'b0;
                                    2'd3: begin
                                        state       <= S_IDLE;
                                        busy_o      <= 1'b0;
                                        cmd_ready_o <= 1'b1;
                                        if (cmd.xfer) begin
                                            rsp_valid_o <= 1'b1;
                                            rx_data_o   <= rx_shift;
                                            rx_nack_o   <= ninth;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
